// File: rtl/lpc_residual_calculator.sv
// LPC residual: loads one frame of quantized coefficients, then emits sample - (prediction >>> shift), 3 enabled cycles per sample.
// No backpressure: oReady in RUN only; iEnable=0 freezes all state, iLoad squashes samples still in the pipeline.
module lpc_residual_calculator #(
    parameter int MAX_ORDER = 12,
    parameter int COEFF_W   = 12,
    parameter int SAMPLE_W  = 16,
    parameter int RES_W     = 32
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iEnable,
    input  logic                iLoad,
    input  logic [3:0]          iOrder,
    input  logic [4:0]          iShift,
    input  logic                iCoeffValid,
    input  logic [COEFF_W-1:0]  iQuantizedCoeff,
    input  logic                iSampleValid,
    input  logic [SAMPLE_W-1:0] iSample,
    output logic                oReady,
    output logic                oValid,
    output logic                oWarmup,
    output logic [RES_W-1:0]    oResidual
);
    localparam int         PROD_W    = COEFF_W + SAMPLE_W;
    localparam int         ACC_W     = SAMPLE_W + COEFF_W + 4;
    localparam int         HALF      = MAX_ORDER / 2;
    localparam logic [3:0] MAX_ORD_4 = 4'(MAX_ORDER);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
    state_t r_state, w_state_next;

    logic [3:0]                 r_order, r_cnt, r_warm_cnt;
    logic [4:0]                 r_shift;
    logic signed [COEFF_W-1:0]  r_coeff [MAX_ORDER];
    logic signed [SAMPLE_W-1:0] r_hist  [MAX_ORDER];

    logic signed [PROD_W-1:0]   r_p1_prod [MAX_ORDER];
    logic signed [SAMPLE_W-1:0] r_p1_sample, r_p2_sample;
    logic                       r_p1_vld, r_p1_warm, r_p2_vld, r_p2_warm;
    logic signed [ACC_W-1:0]    r_p2_sum_lo, r_p2_sum_hi;

    logic [3:0]                 w_order_clamped;
    logic                       w_coeff_wr, w_accept, w_warm, w_emit;
    logic signed [PROD_W-1:0]   w_prod [MAX_ORDER];
    logic signed [ACC_W-1:0]    w_sum_lo, w_sum_hi, w_pred, w_pred_sh, w_diff;

    assign w_order_clamped = (iOrder > MAX_ORD_4) ? MAX_ORD_4 : iOrder;
    assign w_coeff_wr      = iEnable && !iLoad && (r_state == S_LOAD) && iCoeffValid;
    assign w_accept        = iEnable && !iLoad && (r_state == S_RUN) && iSampleValid;
    assign w_warm          = (r_warm_cnt < r_order);
    assign w_emit          = r_p2_vld && !iLoad;
    assign oReady          = (r_state == S_RUN);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (iEnable) begin
            if (iLoad) begin
                w_state_next = (w_order_clamped == 4'd0) ? S_RUN : S_LOAD;
            end else if (w_coeff_wr && (r_cnt == r_order - 4'd1)) begin
                w_state_next = S_RUN;
            end
        end
    end

    // Taps beyond the frame order contribute nothing, whatever a previous frame left in r_coeff.
    always_comb begin
        for (int j = 0; j < MAX_ORDER; j++) begin
            w_prod[j] = '0;
            if (4'(j) < r_order) begin
                w_prod[j] = PROD_W'(r_coeff[j]) * PROD_W'(r_hist[j]);
            end
        end
    end

    always_comb begin
        w_sum_lo = '0;
        w_sum_hi = '0;
        for (int j = 0; j < HALF; j++) begin
            w_sum_lo = w_sum_lo + ACC_W'(r_p1_prod[j]);
        end
        for (int j = HALF; j < MAX_ORDER; j++) begin
            w_sum_hi = w_sum_hi + ACC_W'(r_p1_prod[j]);
        end
    end

    assign w_pred    = r_p2_sum_lo + r_p2_sum_hi;
    assign w_pred_sh = w_pred >>> r_shift;
    assign w_diff    = ACC_W'(r_p2_sample) - w_pred_sh;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_order     <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_warm_cnt  <= '0;
            for (int j = 0; j < MAX_ORDER; j++) begin
                r_coeff[j]   <= '0;
                r_hist[j]    <= '0;
                r_p1_prod[j] <= '0;
            end
            r_p1_vld    <= 1'b0;
            r_p1_warm   <= 1'b0;
            r_p1_sample <= '0;
            r_p2_vld    <= 1'b0;
            r_p2_warm   <= 1'b0;
            r_p2_sample <= '0;
            r_p2_sum_lo <= '0;
            r_p2_sum_hi <= '0;
            oValid      <= 1'b0;
            oWarmup     <= 1'b0;
            oResidual   <= '0;
        end else if (iEnable) begin
            if (iLoad) begin
                r_order    <= w_order_clamped;
                r_shift    <= iShift;
                r_cnt      <= '0;
                r_warm_cnt <= '0;
                for (int j = 0; j < MAX_ORDER; j++) begin
                    r_hist[j] <= '0;
                end
            end
            if (w_coeff_wr) begin
                r_coeff[r_cnt] <= iQuantizedCoeff;
                r_cnt          <= r_cnt + 4'd1;
            end
            // Products use the history before this sample is shifted in: r_hist[0] is x[n-1].
            if (w_accept) begin
                r_hist[0] <= iSample;
                for (int j = 1; j < MAX_ORDER; j++) begin
                    r_hist[j] <= r_hist[j-1];
                end
                if (w_warm) begin
                    r_warm_cnt <= r_warm_cnt + 4'd1;
                end
                for (int j = 0; j < MAX_ORDER; j++) begin
                    r_p1_prod[j] <= w_prod[j];
                end
                r_p1_sample <= iSample;
                r_p1_warm   <= w_warm;
            end
            r_p1_vld <= w_accept;

            if (r_p1_vld) begin
                r_p2_sum_lo <= w_sum_lo;
                r_p2_sum_hi <= w_sum_hi;
                r_p2_sample <= r_p1_sample;
                r_p2_warm   <= r_p1_warm;
            end
            r_p2_vld <= r_p1_vld && !iLoad;

            oValid  <= w_emit;
            oWarmup <= w_emit && r_p2_warm;
            if (w_emit) begin
                oResidual <= r_p2_warm ? RES_W'(r_p2_sample) : RES_W'(w_diff);
            end
        end
    end
endmodule

// File: tb/tb_lpc_residual_calculator.sv
// Bench for lpc_residual_calculator: directed vector table, hand sequences for stall/abort/clamp, random traffic vs a frame-level model.
module tb_lpc_residual_calculator;
    logic        clk = 1'b0;
    logic        iReset, iEnable, iLoad, iCoeffValid, iSampleValid;
    logic [3:0]  iOrder;
    logic [4:0]  iShift;
    logic [11:0] iQuantizedCoeff;
    logic [15:0] iSample;
    logic        oReady, oValid, oWarmup;
    logic [31:0] oResidual;

    always #5 clk = ~clk;

    lpc_residual_calculator dut (
        .iClock(clk), .iReset(iReset), .iEnable(iEnable), .iLoad(iLoad),
        .iOrder(iOrder), .iShift(iShift), .iCoeffValid(iCoeffValid),
        .iQuantizedCoeff(iQuantizedCoeff), .iSampleValid(iSampleValid), .iSample(iSample),
        .oReady(oReady), .oValid(oValid), .oWarmup(oWarmup), .oResidual(oResidual)
    );

    typedef struct {
        logic rst, en, ld;
        logic [3:0] ord;
        logic [4:0] sh;
        logic cv;
        logic [11:0] c;
        logic sv;
        logic [15:0] s;
    } in_t;

    typedef struct {
        in_t i;
        logic rdy, vld, warm;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic vld, warm;
        logic [31:0] res;
    } ent_t;

    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

    int n_checks, n_errors;

    // Frame-level reference: spec states, the frame's sample list (newest first), and the 3-cycle output delay.
    int     m_state, m_order, m_shift, m_cnt, m_nacc;
    longint m_coeff [12];
    longint m_hist [$];
    ent_t   m_s1, m_s2, m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v.rst = 1'b0; v.en = 1'b1; v.ld = 1'b0; v.ord = '0; v.sh = '0;
        v.cv = 1'b0; v.c = '0; v.sv = 1'b0; v.s = '0;
        return v;
    endfunction

    function automatic vec_t mk(input bit ld, input int ord, input int sh, input bit cv, input int c,
                                input bit sv, input int s, input bit rdy, input bit vld, input bit warm,
                                input int res);
        vec_t t;
        t.i = idle();
        t.i.ld = ld; t.i.ord = 4'(ord); t.i.sh = 5'(sh);
        t.i.cv = cv; t.i.c = 12'(c); t.i.sv = sv; t.i.s = 16'(s);
        t.rdy = rdy; t.vld = vld; t.warm = warm; t.res = 32'(res);
        return t;
    endfunction

    function automatic ent_t predict(input logic [15:0] s);
        ent_t   e;
        longint x, p, d, q;
        x = longint'($signed(s));
        e.vld  = 1'b1;
        e.warm = (m_nacc < m_order);
        if (e.warm) begin
            e.res = 32'(x);
        end else begin
            p = 0;
            for (int j = 0; j < m_order; j++)
                if (j < m_hist.size()) p += m_coeff[j] * m_hist[j];
            d = longint'(1) << m_shift;
            q = p / d;
            if (p < 0 && (p % d) != 0) q = q - 1;
            e.res = 32'(x - q);
        end
        return e;
    endfunction

    task automatic model_edge(input in_t v);
        ent_t n;
        int   st;
        n.vld = 1'b0; n.warm = 1'b0; n.res = '0;
        if (v.rst) begin
            m_state = M_IDLE; m_order = 0; m_shift = 0; m_cnt = 0; m_nacc = 0;
            m_hist.delete();
            for (int j = 0; j < 12; j++) m_coeff[j] = 0;
            m_s1 = n; m_s2 = n; m_out = n;
        end else if (v.en) begin
            st = m_state;
            if (v.ld) begin
                m_order = (v.ord > 4'd12) ? 12 : int'(v.ord);
                m_shift = int'(v.sh);
                m_cnt = 0; m_nacc = 0;
                m_hist.delete();
                m_state = (m_order == 0) ? M_RUN : M_LOAD;
                m_out.vld = 1'b0; m_out.warm = 1'b0;
                m_s1 = n; m_s2 = n;
            end else begin
                if (st == M_LOAD && v.cv) begin
                    m_coeff[m_cnt] = longint'($signed(v.c));
                    m_cnt++;
                    if (m_cnt == m_order) m_state = M_RUN;
                end
                if (st == M_RUN && v.sv) begin
                    n = predict(v.s);
                    m_hist.push_front(longint'($signed(v.s)));
                    if (m_hist.size() > 12) void'(m_hist.pop_back());
                    m_nacc++;
                end
                m_out.vld  = m_s2.vld;
                m_out.warm = m_s2.vld && m_s2.warm;
                if (m_s2.vld) m_out.res = m_s2.res;
                m_s2 = m_s1;
                m_s1 = n;
            end
        end
    endtask

    task automatic cyc(input in_t v);
        logic pv, pw, pr;
        logic [31:0] pres;
        pv = oValid; pw = oWarmup; pr = oReady; pres = oResidual;
        iReset = v.rst; iEnable = v.en; iLoad = v.ld; iOrder = v.ord; iShift = v.sh;
        iCoeffValid = v.cv; iQuantizedCoeff = v.c; iSampleValid = v.sv; iSample = v.s;
        @(posedge clk);
        #1;
        model_edge(v);
        if (!v.rst && !v.en) begin
            chk("hold_valid", oValid, pv);
            chk("hold_warmup", oWarmup, pw);
            chk("hold_ready", oReady, pr);
            chk("hold_residual", oResidual, pres);
        end
        chk("valid", oValid, m_out.vld);
        chk("ready", oReady, m_state == M_RUN);
        if (m_out.vld) begin
            chk("warmup", oWarmup, m_out.warm);
            chk("residual", oResidual, m_out.res);
        end
    endtask

    vec_t tbl [$];

    initial begin
        in_t v;
        int  nv;
        n_checks = 0; n_errors = 0;
        m_state = M_IDLE; m_order = 0; m_shift = 0; m_cnt = 0; m_nacc = 0;
        for (int j = 0; j < 12; j++) m_coeff[j] = 0;
        m_s1 = '{1'b0, 1'b0, 32'd0}; m_s2 = m_s1; m_out = m_s1;

        // mk(ld, ord, sh, cv, c, sv, s, rdy, vld, warm, res); expected is sampled after the edge.
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 20, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 35, 1, 1, 1, 10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 15));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, -1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 3, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 5, 1, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, -1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, -1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1024, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, -100, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, -50, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, -100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 50));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 5, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, -3, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, -3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        // Reset with random inputs, then samples with no frame loaded.
        for (int k = 0; k < 2; k++) begin
            v.rst = 1'b1; v.en = 1'b1; v.ld = 1'($urandom); v.ord = 4'($urandom); v.sh = 5'($urandom);
            v.cv = 1'($urandom); v.c = 12'($urandom); v.sv = 1'($urandom); v.s = 16'($urandom);
            cyc(v);
            chk("reset_valid", oValid, 0);
            chk("reset_warmup", oWarmup, 0);
            chk("reset_ready", oReady, 0);
            chk("reset_residual", oResidual, 0);
        end
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            v = idle(); v.sv = 1'b1; v.s = 16'($urandom);
            cyc(v);
            if (oValid) nv++;
        end
        chk("no_frame_no_valid", nv, 0);

        foreach (tbl[k]) begin
            cyc(tbl[k].i);
            chk($sformatf("vec%0d_ready", k), oReady, tbl[k].rdy);
            chk($sformatf("vec%0d_valid", k), oValid, tbl[k].vld);
            if (tbl[k].vld) begin
                chk($sformatf("vec%0d_warmup", k), oWarmup, tbl[k].warm);
                chk($sformatf("vec%0d_residual", k), oResidual, tbl[k].res);
            end
        end

        // Order 12, 20 back-to-back samples with a 4-cycle enable stall mid-stream.
        v = idle(); v.ld = 1'b1; v.ord = 4'd12; v.sh = 5'($urandom_range(0, 31));
        cyc(v);
        for (int k = 0; k < 12; k++) begin
            v = idle(); v.cv = 1'b1; v.c = 12'($urandom);
            cyc(v);
        end
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                for (int t = 0; t < 4; t++) begin
                    v = idle(); v.en = 1'b0; v.sv = 1'b1; v.s = 16'($urandom);
                    v.ld = 1'($urandom); v.cv = 1'b1;
                    cyc(v);
                end
            end
            v = idle(); v.sv = 1'b1; v.s = 16'($urandom);
            cyc(v);
        end
        // Two samples in flight when iLoad arrives: neither may appear.
        v = idle(); v.sv = 1'b1; v.s = 16'($urandom);
        cyc(v);
        v.s = 16'($urandom);
        cyc(v);
        v = idle(); v.ld = 1'b1; v.ord = 4'd15; v.sh = 5'($urandom_range(0, 31));
        cyc(v);
        chk("abort_restarts_load", oReady, 0);
        nv = 0;
        for (int k = 0; k < 5; k++) begin
            v = idle(); v.sv = 1'b1; v.s = 16'($urandom);
            cyc(v);
            if (oValid) nv++;
        end
        chk("abort_squashed", nv, 0);
        for (int k = 0; k < 12; k++) begin
            v = idle(); v.cv = 1'b1; v.c = 12'($urandom);
            cyc(v);
            if (k == 10) chk("clamp_not_ready_after_11", oReady, 0);
        end
        chk("clamp_ready_after_12", oReady, 1);
        for (int k = 0; k < 18; k++) begin
            v = idle(); v.sv = 1'b1; v.s = 16'($urandom);
            cyc(v);
        end
        for (int k = 0; k < 4; k++) cyc(idle());

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            v.rst = ($urandom_range(0, 199) == 0);
            v.en  = v.rst || ($urandom_range(0, 9) != 0);
            v.ld  = ($urandom_range(0, 59) == 0);
            v.ord = 4'($urandom);
            v.sh  = 5'($urandom);
            v.cv  = 1'($urandom);
            v.c   = 12'($urandom);
            v.sv  = ($urandom_range(0, 9) < 7);
            v.s   = 16'($urandom);
            cyc(v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
